// File: rtl/scan_chain_responder.sv
// Scan-chain responder: an L-bit shift register that, on leaving shift mode,
// applies one XOR-folding capture and keeps capture/shift bookkeeping.
module scan_chain_responder #(
   parameter int unsigned SCAN_CHAIN_LENGTH = 263,
   parameter int unsigned CAPTURE_TAP       = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cut_scanmode,
   input  logic        cut_sdi,
   output logic        cut_sdo,
   output logic [15:0] capture_count,
   output logic [8:0]  shift_count,
   output logic        shift_len_err,
   output logic [1:0]  resp_state
);

   localparam int unsigned L = SCAN_CHAIN_LENGTH;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StCapt  = 2'b10,
      StHold  = 2'b11
   } state_e;

   state_e         state_q, state_d;
   logic [L-1:0]   chain_q, chain_d;
   logic [L-1:0]   capture_val;
   logic [15:0]    capture_count_q, capture_count_d;
   logic [8:0]     shift_count_q, shift_count_d;
   logic           shift_len_err_q, shift_len_err_d;

   // Capture function: every bit folds in its next neighbour and the tap bit (pre-edge values).
   always_comb begin
      capture_val = '0;
      for (int unsigned i = 0; i < L; i++) begin
         capture_val[i] = chain_q[i] ^ chain_q[(i + 1) % L] ^ chain_q[(i + CAPTURE_TAP) % L];
      end
   end

   // Next-state: shift has priority in every state; capture only on SHIFT -> scanmode low.
   always_comb begin
      state_d         = state_q;
      chain_d         = chain_q;
      capture_count_d = capture_count_q;
      shift_count_d   = shift_count_q;
      shift_len_err_d = shift_len_err_q;
      if (cut_scanmode) begin
         chain_d       = {chain_q[L-2:0], cut_sdi};
         shift_count_d = (shift_count_q == 9'd511) ? shift_count_q : shift_count_q + 9'd1;
         state_d       = StShift;
      end else begin
         unique case (state_q)
            StShift: begin
               chain_d         = capture_val;
               capture_count_d = capture_count_q + 16'd1;
               if (shift_count_q != 9'(L)) begin
                  shift_len_err_d = 1'b1;
               end
               shift_count_d   = '0;
               state_d         = StCapt;
            end
            StCapt:  state_d = StHold;
            StHold:  state_d = StHold;
            default: state_d = StIdle;
         endcase
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= StIdle;
         chain_q         <= '0;
         capture_count_q <= '0;
         shift_count_q   <= '0;
         shift_len_err_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         chain_q         <= chain_d;
         capture_count_q <= capture_count_d;
         shift_count_q   <= shift_count_d;
         shift_len_err_q <= shift_len_err_d;
      end
   end

   assign cut_sdo       = chain_q[L-1];
   assign capture_count = capture_count_q;
   assign shift_count   = shift_count_q;
   assign shift_len_err = shift_len_err_q;
   assign resp_state    = state_q;

endmodule

// File: tb/tb_scan_chain_responder.sv
// Directed bench: small chain (L=8, tap 3) for exact data checks, default chain for long runs.
module tb_scan_chain_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cut_scanmode = 1'b0;
   logic        cut_sdi = 1'b0;

   logic        sdo_s, err_s;
   logic [15:0] cap_s;
   logic [8:0]  shc_s;
   logic [1:0]  st_s;

   logic        sdo_d, err_d;
   logic [15:0] cap_d;
   logic [8:0]  shc_d;
   logic [1:0]  st_d;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   scan_chain_responder #(
      .SCAN_CHAIN_LENGTH(8),
      .CAPTURE_TAP      (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cut_scanmode (cut_scanmode),
      .cut_sdi      (cut_sdi),
      .cut_sdo      (sdo_s),
      .capture_count(cap_s),
      .shift_count  (shc_s),
      .shift_len_err(err_s),
      .resp_state   (st_s)
   );

   scan_chain_responder dut_d (
      .clk          (clk),
      .rst          (rst),
      .cut_scanmode (cut_scanmode),
      .cut_sdi      (cut_sdi),
      .cut_sdo      (sdo_d),
      .capture_count(cap_d),
      .shift_count  (shc_d),
      .shift_len_err(err_d),
      .resp_state   (st_d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive inputs, take one rising edge, return 1 time unit after it.
   task automatic tick(input logic sm, input logic di);
      cut_scanmode = sm;
      cut_sdi      = di;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(st_s), 32'd0);
      chk({tag, "_sdo"},   32'(sdo_s), 32'd0);
      chk({tag, "_cap"},   32'(cap_s), 32'd0);
      chk({tag, "_shc"},   32'(shc_s), 32'd0);
      chk({tag, "_err"},   32'(err_s), 32'd0);
      chk({tag, "_chain"}, 32'(dut.chain_q), 32'd0);
   endtask

   logic [7:0]   sdo_exp;
   logic [7:0]   pat;
   logic [262:0] exp_d;

   initial begin
      // Reset asserted at time 0, before any clock edge.
      #3;
      chk_reset_vals("rst0");

      // Inputs ignored while held in reset.
      cut_scanmode = 1'b1;
      cut_sdi      = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_reset_vals("rst_hold");
      rst = 1'b1;

      // Leaving IDLE with scanmode low must not capture.
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("idle_state", 32'(st_s), 32'd0);
      chk("idle_cap",   32'(cap_s), 32'd0);

      // Shift in 0x01.
      for (int i = 0; i < 8; i++) tick(1'b1, (i == 7));
      chk("sh01_chain", 32'(dut.chain_q), 32'h01);
      chk("sh01_shc",   32'(shc_s), 32'd8);
      chk("sh01_state", 32'(st_s), 32'd1);
      chk("sh01_sdo",   32'(sdo_s), 32'd0);

      // One capture over a three-cycle low period.
      tick(1'b0, 1'b0);
      chk("cap1_state", 32'(st_s), 32'd2);
      chk("cap1_chain", 32'(dut.chain_q), 32'hA1);
      chk("cap1_cap",   32'(cap_s), 32'd1);
      chk("cap1_shc",   32'(shc_s), 32'd0);
      chk("cap1_err",   32'(err_s), 32'd0);
      chk("cap1_sdo",   32'(sdo_s), 32'd1);
      tick(1'b0, 1'b0);
      chk("hold1_state", 32'(st_s), 32'd3);
      tick(1'b0, 1'b0);
      chk("hold2_state", 32'(st_s), 32'd3);
      chk("hold2_cap",   32'(cap_s), 32'd1);
      chk("hold2_chain", 32'(dut.chain_q), 32'hA1);

      // Unload: sdo read before each edge.
      sdo_exp = 8'b1010_0001;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("unload_sdo%0d", i), 32'(sdo_s), 32'(sdo_exp[7-i]));
         tick(1'b1, 1'b0);
      end
      chk("unload_chain", 32'(dut.chain_q), 32'h00);
      chk("unload_shc",   32'(shc_s), 32'd8);

      // Second data pattern 0x0F exercises every tap term.
      pulse_reset();
      pat = 8'h0F;
      for (int i = 0; i < 8; i++) tick(1'b1, pat[7-i]);
      chk("sh0f_chain", 32'(dut.chain_q), 32'h0F);
      tick(1'b0, 1'b0);
      chk("cap0f_chain", 32'(dut.chain_q), 32'h69);
      chk("cap0f_err",   32'(err_s), 32'd0);

      // Short shift sets the sticky error; a correct-length run does not clear it.
      pulse_reset();
      chk_reset_vals("rst2");
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("short_cap", 32'(cap_s), 32'd1);
      chk("short_err", 32'(err_s), 32'd1);
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("sticky_err", 32'(err_s), 32'd1);
      chk("sticky_cap", 32'(cap_s), 32'd2);

      // Shift counter saturates at 511.
      for (int i = 0; i < 520; i++) tick(1'b1, 1'b0);
      chk("sat_shc", 32'(shc_s), 32'd511);
      tick(1'b0, 1'b0);
      chk("sat_cap", 32'(cap_s), 32'd3);
      chk("sat_shc0", 32'(shc_s), 32'd0);

      // Asynchronous reset mid-shift discards everything.
      pulse_reset();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
      chk("mid_chain", 32'(dut.chain_q), 32'h0F);
      rst = 1'b0;
      #1;
      chk_reset_vals("async");
      #1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("post_rst_chain", 32'(dut.chain_q), 32'h00);
      chk("post_rst_cap",   32'(cap_s), 32'd1);
      chk("post_rst_err",   32'(err_s), 32'd0);

      // Default geometry: single-one capture, then a run of full-length patterns.
      pulse_reset();
      for (int i = 0; i < 263; i++) tick(1'b1, (i == 262));
      chk("def_shc", 32'(shc_d), 32'd263);
      tick(1'b0, 1'b0);
      exp_d = '0;
      exp_d[0]   = 1'b1;
      exp_d[262] = 1'b1;
      exp_d[256] = 1'b1;
      n_tests++;
      assert (dut_d.chain_q === exp_d) else begin
         n_fail++;
         $error("FAIL def_cap_chain: observed 0x%0h expected 0x%0h", dut_d.chain_q, exp_d);
      end
      chk("def_sdo", 32'(sdo_d), 32'd1);
      for (int p = 1; p < 40; p++) begin
         for (int i = 0; i < 263; i++) tick(1'b1, 1'($urandom_range(1, 0)));
         tick(1'b0, 1'b0);
      end
      chk("def_cap", 32'(cap_d), 32'd40);
      chk("def_err", 32'(err_d), 32'd0);
      chk("def_shc0", 32'(shc_d), 32'd0);
      chk("def_state", 32'(st_d), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
